bip_control: RTL and testbench

Parametrised control unit for the BIP accumulator processor. Holds the program counter, decodes the current instruction (opcode + operand) into datapath and data-memory strobes, and extends the original straight-line sequencer with jumps, accumulator-conditional branches, a pipeline-style enable, a sticky halt state and a saturating executed-instruction counter. Sits between the program memory (asynchronous read, addressed by `address`) and the accumulator/ALU datapath.

---
 rtl/bip_control.sv | 198 +++++++++++++++++++
 tb/tb_bip_control.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bip_control.sv
// bip_control: program counter, instruction decoder and run/halt sequencer
// for the BIP accumulator processor. The decode strobes are combinational
// from the presented opcode. PC, run state and the executed-instruction
// counter are registered. Jumps and branches redirect the PC with no delay
// slot. HLT is sticky until reset.
module bip_control #(
  parameter int OPCODE_LENGTH  = 5,
  parameter int OPERAND_LENGTH = 11,
  parameter int ADDRESS_LENGTH = 11,
  parameter int COUNTER_LENGTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [OPCODE_LENGTH-1:0]  opcode,
  input  logic [OPERAND_LENGTH-1:0] operand,
  input  logic                      acc_zero,
  output logic [ADDRESS_LENGTH-1:0] address,
  output logic [1:0]                sel_a,
  output logic                      sel_b,
  output logic                      wr_acc,
  output logic                      op,
  output logic                      wr_ram,
  output logic                      rd_ram,
  output logic                      halted,
  output logic [COUNTER_LENGTH-1:0] cycle_count
);

  // Instruction encodings
  localparam logic [OPCODE_LENGTH-1:0] OP_HLT  = OPCODE_LENGTH'(5'd0);
  localparam logic [OPCODE_LENGTH-1:0] OP_STO  = OPCODE_LENGTH'(5'd1);
  localparam logic [OPCODE_LENGTH-1:0] OP_LD   = OPCODE_LENGTH'(5'd2);
  localparam logic [OPCODE_LENGTH-1:0] OP_LDI  = OPCODE_LENGTH'(5'd3);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(5'd4);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADDI = OPCODE_LENGTH'(5'd5);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(5'd6);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUBI = OPCODE_LENGTH'(5'd7);
  localparam logic [OPCODE_LENGTH-1:0] OP_JMP  = OPCODE_LENGTH'(5'd8);
  localparam logic [OPCODE_LENGTH-1:0] OP_BEQ  = OPCODE_LENGTH'(5'd9);
  localparam logic [OPCODE_LENGTH-1:0] OP_BNE  = OPCODE_LENGTH'(5'd10);

  // Accumulator input mux selections
  localparam logic [1:0] SEL_A_MEM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDRESS_LENGTH-1:0] pc_q, pc_d;
  logic [COUNTER_LENGTH-1:0] cnt_q, cnt_d;

  logic                      running_s;
  logic                      execute_s;
  logic [ADDRESS_LENGTH-1:0] target_s;
  logic [ADDRESS_LENGTH-1:0] pc_inc_s;

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [COUNTER_LENGTH-1:0] sat_inc(
    input logic [COUNTER_LENGTH-1:0] value
  );
    logic [COUNTER_LENGTH-1:0] result;
    if (&value) begin
      result = value;
    end else begin
      result = value + COUNTER_LENGTH'(1'b1);
    end
    return result;
  endfunction

  // The jump/branch target is taken from the low operand bits
  assign target_s  = operand[ADDRESS_LENGTH-1:0];
  assign pc_inc_s  = pc_q + ADDRESS_LENGTH'(1'b1);

  // Decode is live only in RUN outside reset. Execution also needs enable.
  assign running_s = (!reset) && (state_q == ST_RUN);
  assign execute_s = running_s && enable;

  // Instruction decode: mux selects follow the opcode while running, and
  // the write/read strobes are additionally gated by enable
  always_comb begin
    sel_a  = SEL_A_MEM;
    sel_b  = 1'b0;
    op     = 1'b0;
    wr_acc = 1'b0;
    wr_ram = 1'b0;
    rd_ram = 1'b0;
    if (running_s) begin
      case (opcode)
        OP_STO: begin
          wr_ram = enable;
        end
        OP_LD: begin
          rd_ram = enable;
          wr_acc = enable;
          sel_a  = SEL_A_MEM;
        end
        OP_LDI: begin
          wr_acc = enable;
          sel_a  = SEL_A_IMM;
        end
        OP_ADD: begin
          rd_ram = enable;
          wr_acc = enable;
          sel_a  = SEL_A_ALU;
          sel_b  = 1'b0;
          op     = 1'b0;
        end
        OP_ADDI: begin
          wr_acc = enable;
          sel_a  = SEL_A_ALU;
          sel_b  = 1'b1;
          op     = 1'b0;
        end
        OP_SUB: begin
          rd_ram = enable;
          wr_acc = enable;
          sel_a  = SEL_A_ALU;
          sel_b  = 1'b0;
          op     = 1'b1;
        end
        OP_SUBI: begin
          wr_acc = enable;
          sel_a  = SEL_A_ALU;
          sel_b  = 1'b1;
          op     = 1'b1;
        end
        default: begin
          // HLT, jumps, branches and NOPs drive no datapath strobes
          sel_a = SEL_A_MEM;
        end
      endcase
    end else begin
      // Reset cycle and HALT keep every strobe low
      sel_a = SEL_A_MEM;
    end
  end

  // Next-state logic: PC redirect or advance, HALT entry, counter increment
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (execute_s) begin
      cnt_d = sat_inc(cnt_q);
      case (opcode)
        OP_HLT: begin
          state_d = ST_HALT;
          pc_d    = pc_q;
        end
        OP_JMP: begin
          pc_d = target_s;
        end
        OP_BEQ: begin
          if (acc_zero) begin
            pc_d = target_s;
          end else begin
            pc_d = pc_inc_s;
          end
        end
        OP_BNE: begin
          if (!acc_zero) begin
            pc_d = target_s;
          end else begin
            pc_d = pc_inc_s;
          end
        end
        default: begin
          pc_d = pc_inc_s;
        end
      endcase
    end else begin
      // Stall, HALT or reset cycle: the reset branch of the register wins
      state_d = state_q;
    end
  end

  // State, PC and counter registers with synchronous reset priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign address     = pc_q;
  assign cycle_count = cnt_q;
  assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: directed and randomized checks of bip_control against a
// behavioural model built from the instruction-set rules.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [4:0]  opcode;
  logic [10:0] operand;
  logic        acc_zero;

  logic [10:0] address;
  logic [1:0]  sel_a;
  logic        sel_b, wr_acc, op, wr_ram, rd_ram, halted;
  logic [31:0] cycle_count;

  logic [10:0] address4;
  logic [1:0]  sel_a4;
  logic        sel_b4, wr_acc4, op4, wr_ram4, rd_ram4, halted4;
  logic [3:0]  cycle_count4;

  always #5 clk = ~clk;

  bip_control dut (
    .clk(clk), .reset(reset), .enable(enable), .opcode(opcode),
    .operand(operand), .acc_zero(acc_zero), .address(address),
    .sel_a(sel_a), .sel_b(sel_b), .wr_acc(wr_acc), .op(op),
    .wr_ram(wr_ram), .rd_ram(rd_ram), .halted(halted),
    .cycle_count(cycle_count)
  );

  bip_control #(.COUNTER_LENGTH(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .opcode(opcode),
    .operand(operand), .acc_zero(acc_zero), .address(address4),
    .sel_a(sel_a4), .sel_b(sel_b4), .wr_acc(wr_acc4), .op(op4),
    .wr_ram(wr_ram4), .rd_ram(rd_ram4), .halted(halted4),
    .cycle_count(cycle_count4)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  int m_pc   = 0;
  bit m_halt = 1'b0;
  int m_cnt  = 0;

  // Snapshot of the combinational outputs (mid-cycle) and their expectation
  logic [2:0] obs_strb, obs4_strb, exp_strb;
  logic [3:0] obs_dec, obs4_dec, exp_dec;
  bit         chk_dec;

  // Instruction table {wr_acc, wr_ram, rd_ram, sel_a, sel_b, op}
  function automatic logic [6:0] ref_decode(input int opc);
    case (opc)
      1:       return 7'b010_00_0_0;
      2:       return 7'b101_00_0_0;
      3:       return 7'b100_01_0_0;
      4:       return 7'b101_10_0_0;
      5:       return 7'b100_10_1_0;
      6:       return 7'b101_10_0_1;
      7:       return 7'b100_10_1_1;
      default: return 7'b000_00_0_0;
    endcase
  endfunction

  function automatic int cnt4(input int c);
    return (c > 15) ? 15 : c;
  endfunction

  // Drive one instruction for one clock, snapshot outputs, advance the model
  task automatic apply(input bit rst, input bit en, input int opc,
                       input int opd, input bit az);
    logic [6:0] d;
    reset = rst; enable = en; opcode = 5'(opc); operand = 11'(opd);
    acc_zero = az;
    d = ref_decode(opc);
    if (rst || m_halt || !en) begin
      exp_strb = 3'b000; exp_dec = 4'b0000; chk_dec = 1'b0;
    end else begin
      exp_strb = d[6:4]; exp_dec = d[3:0]; chk_dec = 1'b1;
    end
    #4;
    obs_strb  = {wr_acc, wr_ram, rd_ram};
    obs_dec   = {sel_a, sel_b, op};
    obs4_strb = {wr_acc4, wr_ram4, rd_ram4};
    obs4_dec  = {sel_a4, sel_b4, op4};
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_halt = 1'b0; m_cnt = 0;
    end else if (!m_halt && en) begin
      m_cnt++;
      if (opc == 0) m_halt = 1'b1;
      else if (opc == 8 || (opc == 9 && az) || (opc == 10 && !az))
        m_pc = opd % 2048;
      else
        m_pc = (m_pc + 1) % 2048;
    end
    #1;
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, 3, 5, 1'b0);
    apply(1'b1, 1'b1, 1, 0, 1'b0);
    n_total++; if (obs_strb !== 3'b000) $display("FAIL reset_strobes got %b want 000", obs_strb); else n_pass++;
    n_total++; if (address !== 11'd0) $display("FAIL reset_addr got %h want 000", address); else n_pass++;
    n_total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else n_pass++;
    n_total++; if (cycle_count !== 32'd0) $display("FAIL reset_count got %0d want 0", cycle_count); else n_pass++;
  endtask

  task automatic test_program();
    apply(1'b0, 1'b1, 3, 5, 1'b0);   // LDI 5
    n_total++; if ({obs_strb, obs_dec[3:2]} !== 5'b100_01) $display("FAIL ldi_dec got %b want 10001", {obs_strb, obs_dec[3:2]}); else n_pass++;
    n_total++; if (address !== 11'd1) $display("FAIL ldi_addr got %h want 001", address); else n_pass++;
    apply(1'b0, 1'b1, 5, 3, 1'b0);   // ADDI 3
    n_total++; if ({obs_strb, obs_dec} !== 7'b100_10_1_0) $display("FAIL addi_dec got %b want 1001010", {obs_strb, obs_dec}); else n_pass++;
    n_total++; if (address !== 11'd2) $display("FAIL addi_addr got %h want 002", address); else n_pass++;
    apply(1'b0, 1'b1, 1, 2, 1'b0);   // STO 2
    n_total++; if (obs_strb !== 3'b010) $display("FAIL sto_strb got %b want 010", obs_strb); else n_pass++;
    n_total++; if (address !== 11'd3) $display("FAIL sto_addr got %h want 003", address); else n_pass++;
    n_total++; if (cycle_count !== 32'd3) $display("FAIL prog_count got %0d want 3", cycle_count); else n_pass++;
  endtask

  task automatic test_branch();
    apply(1'b0, 1'b1, 8, 'h40, 1'b0);
    n_total++; if (address !== 11'h040) $display("FAIL jmp got %h want 040", address); else n_pass++;
    apply(1'b0, 1'b1, 9, 'h10, 1'b1);
    n_total++; if (address !== 11'h010) $display("FAIL beq_taken got %h want 010", address); else n_pass++;
    apply(1'b0, 1'b1, 9, 'h30, 1'b0);
    n_total++; if (address !== 11'h011) $display("FAIL beq_not got %h want 011", address); else n_pass++;
    apply(1'b0, 1'b1, 10, 'h20, 1'b0);
    n_total++; if (address !== 11'h020) $display("FAIL bne_taken got %h want 020", address); else n_pass++;
    apply(1'b0, 1'b1, 10, 'h50, 1'b1);
    n_total++; if (address !== 11'h021) $display("FAIL bne_not got %h want 021", address); else n_pass++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1, 5, 1'b0);
      n_total++; if (obs_strb !== 3'b000) $display("FAIL stall_strb got %b want 000", obs_strb); else n_pass++;
      n_total++; if (address !== 11'h021 || cycle_count !== 32'd8) $display("FAIL stall_hold got %h/%0d want 021/8", address, cycle_count); else n_pass++;
    end
    apply(1'b0, 1'b1, 11, 0, 1'b0);
    n_total++; if (address !== 11'h022 || cycle_count !== 32'd9) $display("FAIL stall_resume got %h/%0d want 022/9", address, cycle_count); else n_pass++;
  endtask

  task automatic test_halt();
    apply(1'b1, 1'b0, 11, 0, 1'b0);
    for (int i = 0; i < 7; i++) apply(1'b0, 1'b1, 11, 0, 1'b0);
    apply(1'b0, 1'b1, 0, 'h55, 1'b0);
    n_total++; if (halted !== 1'b1 || address !== 11'd7) $display("FAIL hlt_enter got %b/%h want 1/007", halted, address); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 10), $urandom, 1'($urandom_range(0, 1)));
      n_total++; if (obs_strb !== 3'b000 || address !== 11'd7 || halted !== 1'b1 || cycle_count !== 32'd8)
        $display("FAIL hlt_hold strb %b addr %h halt %b cnt %0d want 000/007/1/8", obs_strb, address, halted, cycle_count); else n_pass++;
    end
    apply(1'b1, 1'b1, 8, 'h12, 1'b0);
    n_total++; if (address !== 11'd0 || halted !== 1'b0 || cycle_count !== 32'd0) $display("FAIL hlt_reset got %h/%b/%0d want 000/0/0", address, halted, cycle_count); else n_pass++;
  endtask

  task automatic test_wrap_saturate();
    apply(1'b0, 1'b1, 8, 'h7FF, 1'b0);
    apply(1'b0, 1'b1, 20, 0, 1'b0);
    n_total++; if (address !== 11'h000) $display("FAIL pc_wrap got %h want 000", address); else n_pass++;
    apply(1'b1, 1'b0, 11, 0, 1'b0);
    for (int i = 0; i < 20; i++) apply(1'b0, 1'b1, 31, 0, 1'b0);
    n_total++; if (cycle_count4 !== 4'd15) $display("FAIL count_sat got %0d want 15", cycle_count4); else n_pass++;
    n_total++; if (cycle_count !== 32'd20) $display("FAIL count_wide got %0d want 20", cycle_count); else n_pass++;
  endtask

  task automatic test_reset_priority();
    apply(1'b0, 1'b0, 1, 0, 1'b0);
    apply(1'b1, 1'b0, 1, 0, 1'b0);
    n_total++; if (address !== 11'd0 || cycle_count !== 32'd0 || halted !== 1'b0) $display("FAIL rst_stall got %h/%0d want 000/0", address, cycle_count); else n_pass++;
    apply(1'b0, 1'b1, 11, 0, 1'b0);
    apply(1'b1, 1'b1, 8, 'h3C0, 1'b0);
    n_total++; if (address !== 11'd0 || cycle_count !== 32'd0) $display("FAIL rst_branch got %h/%0d want 000/0", address, cycle_count); else n_pass++;
    n_total++; if (obs_strb !== 3'b000) $display("FAIL rst_branch_strb got %b want 000", obs_strb); else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      bit rst = ($urandom_range(0, 39) == 0);
      bit en  = ($urandom_range(0, 4) != 0);
      apply(rst, en, $urandom_range(0, 31), $urandom_range(0, 2047), 1'($urandom_range(0, 1)));
      n_total++;
      if (obs_strb !== exp_strb || obs4_strb !== exp_strb || (chk_dec && (obs_dec !== exp_dec || obs4_dec !== exp_dec))) begin
        if (errs < 10) $display("FAIL rand_decode step %0d got %b/%b want %b/%b", i, obs_strb, obs_dec, exp_strb, exp_dec);
        errs++;
      end else n_pass++;
      n_total++;
      if (address !== 11'(m_pc) || address4 !== 11'(m_pc) || halted !== m_halt || halted4 !== m_halt ||
          cycle_count !== 32'(m_cnt) || cycle_count4 !== 4'(cnt4(m_cnt))) begin
        if (errs < 10) $display("FAIL rand_state step %0d got %h/%b/%0d/%0d want %h/%b/%0d/%0d", i, address, halted,
                                cycle_count, cycle_count4, 11'(m_pc), m_halt, m_cnt, cnt4(m_cnt));
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_branch();
    test_stall();
    test_halt();
    test_wrap_saturate();
    test_reset_priority();
    apply(1'b1, 1'b0, 11, 0, 1'b0);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
